stopwatch_btn_cond: RTL and testbench
=====================================

Name: stopwatch_btn_cond

Overview:
Input conditioning stage directly upstream of the stopwatch top-level counter logic. It synchronises, debounces and edge-detects NBTN raw push-button pins (start/stop, lap, clear) from ui_in. It produces clean levels plus single-cycle press/release pulses for the stopwatch control FSM. Purely sequential per-channel logic, replicated NBTN times.

Parameters:
NBTN, 3, number of independent button channels
SYNC_STAGES, 2, flip-flop synchroniser depth (legal range 2..4)
DB_CYCLES, 50000, consecutive cycles a synchronised input must differ from the stable level before the level is accepted (5 ms at 10 MHz); must be ≥2
DB_W, 16, debounce counter width; must satisfy 2^DB_W > DB_CYCLES
LONG_CYCLES, 10000000, hold time for a long-press pulse (1 s at 10 MHz); only used with the optional feature
LONG_W, 24, long-press counter width; must satisfy 2^LONG_W > LONG_CYCLES

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when 0, all pulse outputs are forced to 0 (state keeps running)
btn_i  input  NBTN  raw asynchronous button pins, active high
level_o  output  NBTN  debounced stable level per channel
press_o  output  NBTN  one-cycle pulse on each accepted 0->1 transition
release_o  output  NBTN  one-cycle pulse on each accepted 1->0 transition
long_o  output  NBTN  one-cycle long-press pulse (optional feature; otherwise constant 0)

Behaviour:
- Reset, asynchronous on rst_n low: synchroniser flops 0; level_o 0; press_o, release_o and long_o 0; all counters 0. Release of reset takes effect at the next clk edge.
- Synchroniser: SYNC_STAGES flops per channel. Output sync[k] is the last stage. No other logic touches btn_i.
- Debounce, per channel, with registered cnt:
  - sync == level: cnt <= 0.
  - sync != level and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - sync != level and cnt == DB_CYCLES-1: level <= sync; cnt <= 0; press (if sync=1) or release (if sync=0) pulses in the same cycle level_o updates.
- Glitch rejection: any return of sync to the level before acceptance clears cnt. A bounce of length < DB_CYCLES never changes level_o.
- Latency: a clean step on btn_i changes level_o exactly SYNC_STAGES+DB_CYCLES clk edges after the first edge that samples the new value.
- Pulse outputs are registered, high for exactly one cycle, and gated by ena. No pulse is deferred: an event occurring while ena=0 is lost.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle.
- Counters saturate logically via the compare and never wrap. Outputs stay glitch-free.
- Reset mid-debounce discards the partial count. After reset a button held high needs the full latency before press_o fires, so a held button yields a press after reset.

Optional Feature:
Macro STOPWATCH_BTN_LONGPRESS_EN.
- Defined:
  - Per-channel hold counter hcnt (LONG_W bits) increments each cycle while level=1 and cleared while level=0.
  - When hcnt == LONG_CYCLES-1, long_o pulses for one cycle (gated by ena) and hcnt stops (holds) until release. Exactly one long pulse per hold.
  - press_o is still emitted at the press; release_o is still emitted at the release.
- Not defined: long_o tied to 0; no hold counters are synthesised.

Decomposition:
- Shared package stopwatch_pkg:
  - button index constants BTN_STARTSTOP=0, BTN_LAP=1, BTN_CLEAR=2
  - default timing constants CLK_HZ, DB_MS and the derived DB_CYCLES
  - shared with the stopwatch top.
- Natural sub-module stopwatch_btn_chan: one channel (synchroniser, debounce counter, level, pulse registers, optional hold counter). The top generates NBTN instances and applies the ena gating.

Test Plan:
Sim parameters: SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=10, NBTN=3.
1. Reset: hold rst_n=0 with btn_i=3'b111 -> all outputs 0. After release, level_o=3'b111 and press_o=3'b111 for one cycle exactly 6 edges after the first sampling edge.
2. Bounce: btn_i[0] high for 3 cycles then low, repeated 5 times -> level_o[0] stays 0; no press_o, release_o or long_o activity.
3. Clean press/release on ch1: btn_i[1] high for 8 cycles then low -> press_o[1] one cycle at edge 6; release_o[1] one cycle 6 edges after the fall; level_o[1] high for exactly 8 cycles.
4. Gating: ena=0 during an accepted press on ch2 -> level_o[2]=1 and press_o stays 0. With ena=1 at release, release_o[2] pulses.
5. Long press (macro defined): hold ch0 for 20 cycles -> press_o[0] at accept; long_o[0] exactly one pulse 10 cycles later; none afterwards. With the macro undefined, long_o == 0 throughout.
6. Reset mid-debounce: assert rst_n=0 two cycles into a ch1 transition -> outputs cleared immediately. After release, the full 6-edge latency is required again.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: button indices and default timing.
// Used by the button conditioner and the stopwatch top.
package stopwatch_pkg;

    localparam int BTN_STARTSTOP = 0;
    localparam int BTN_LAP       = 1;
    localparam int BTN_CLEAR     = 2;
    localparam int BTN_COUNT     = 3;

    localparam int CLK_HZ      = 10_000_000;
    localparam int DB_MS       = 5;
    localparam int LONG_MS     = 1000;
    localparam int DB_CYCLES   = (CLK_HZ / 1000) * DB_MS;
    localparam int LONG_CYCLES = (CLK_HZ / 1000) * LONG_MS;

endpackage

// File: rtl/stopwatch_btn_chan.sv
// One button channel: synchroniser, debounce, edge pulses.
// Hold counter present only with STOPWATCH_BTN_LONGPRESS_EN.
module stopwatch_btn_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = stopwatch_pkg::DB_CYCLES,
    parameter int DB_W        = 16,
    parameter int LONG_CYCLES = stopwatch_pkg::LONG_CYCLES,
    parameter int LONG_W      = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_hit
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DB_CYCLES < 2 ||
        (DB_CYCLES >> DB_W) != 0 || LONG_CYCLES < 2 ||
        (LONG_CYCLES >> LONG_W) != 0) begin : g_bad_cfg
        $error("stopwatch_btn_chan: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                // accept: pulses land in the same cycle as the level
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef STOPWATCH_BTN_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_STOP = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] hcnt;

    // hcnt parks one past the trigger value so a hold fires once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            long_hit <= 1'b0;
        end else begin
            long_hit <= level && (hcnt == LONG_LAST);
            if (!level) begin
                hcnt <= '0;
            end else if (hcnt != LONG_STOP) begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end
`else
    assign long_hit = 1'b0;
`endif

endmodule

// File: rtl/stopwatch_btn_cond.sv
// Button conditioner: NBTN debounced channels with ena-gated pulses.
// Optional long-press detect: define STOPWATCH_BTN_LONGPRESS_EN.
module stopwatch_btn_cond #(
    parameter int NBTN        = stopwatch_pkg::BTN_COUNT,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = stopwatch_pkg::DB_CYCLES,
    parameter int DB_W        = 16,
    parameter int LONG_CYCLES = stopwatch_pkg::LONG_CYCLES,
    parameter int LONG_W      = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] level_o,
    output logic [NBTN-1:0] press_o,
    output logic [NBTN-1:0] release_o,
    output logic [NBTN-1:0] long_o
);

    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] fall;
    logic [NBTN-1:0] long_hit;

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        stopwatch_btn_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .DB_W        (DB_W),
            .LONG_CYCLES (LONG_CYCLES),
            .LONG_W      (LONG_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn      (btn_i[i]),
            .level    (level_o[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .long_hit (long_hit[i])
        );
    end

    // pulses are dropped, not deferred, while disabled
    assign press_o   = rise & {NBTN{ena}};
    assign release_o = fall & {NBTN{ena}};
    assign long_o    = long_hit & {NBTN{ena}};

endmodule

// File: tb/tb_stopwatch_btn_cond.sv
// Bench for stopwatch_btn_cond: scenario tasks plus randomized
// stimulus against a sample-window reference model.
module tb_stopwatch_btn_cond;

    localparam int NB = 3;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int LC = 10;
    localparam int HD = SS + DB;
`ifdef STOPWATCH_BTN_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [NB-1:0] btn_i = '0;
    logic [NB-1:0] level_o, press_o, release_o, long_o;

    always #5 clk = ~clk;

    stopwatch_btn_cond #(
        .NBTN(NB), .SYNC_STAGES(SS), .DB_CYCLES(DB), .DB_W(4),
        .LONG_CYCLES(LC), .LONG_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_i(btn_i),
        .level_o(level_o), .press_o(press_o),
        .release_o(release_o), .long_o(long_o)
    );

    // Model: level flips once the last DB synchronised samples
    // all disagree with it; long fires LC edges after a press.
    bit            hist [NB][HD];
    logic [NB-1:0] m_level, m_press, m_rel, m_long;
    int            m_age [NB];
    int            n_pass = 0;
    int            n_total = 0;

    function automatic void model_reset();
        for (int c = 0; c < NB; c++) begin
            for (int k = 0; k < HD; k++) hist[c][k] = 1'b0;
            m_age[c] = 0;
        end
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
    endfunction

    function automatic void model_edge();
        bit pre;
        bit flip;
        for (int c = 0; c < NB; c++) begin
            pre  = m_level[c];
            flip = 1'b1;
            for (int k = HD - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = btn_i[c];
            for (int k = SS; k < HD; k++)
                if (hist[c][k] == pre) flip = 1'b0;
            m_age[c]   = pre ? m_age[c] + 1 : 0;
            m_long[c]  = LONG_EN && pre && (m_age[c] == LC);
            m_press[c] = flip && !pre;
            m_rel[c]   = flip && pre;
            if (flip) m_level[c] = !pre;
        end
    endfunction

    function automatic logic [4*NB-1:0] exp_vec();
        logic [NB-1:0] g;
        g = {NB{ena}};
        return {m_level, m_press & g, m_rel & g, m_long & g};
    endfunction

    task automatic tick(input logic [NB-1:0] b);
        @(negedge clk);
        btn_i = b;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        int first = 0;
        int npress = 0;
        ena = 1'b1;
        rst_n = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            tick(3'b111);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== '0)
                $display("FAIL reset_hold: got %b want 0",
                         {level_o, press_o, release_o, long_o});
            else n_pass++;
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick(3'b111);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== exp_vec())
                $display("FAIL reset_model edge%0d: got %b want %b", n,
                         {level_o, press_o, release_o, long_o}, exp_vec());
            else n_pass++;
            if (press_o != '0) npress++;
            if (press_o === 3'b111 && level_o === 3'b111 && first == 0)
                first = n;
        end
        n_total++;
        if (first != 6 || npress != 1)
            $display("FAIL reset_latency: got edge %0d (%0d pulses) want edge 6 (1)",
                     first, npress);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int act = 0;
        for (int n = 0; n < 10; n++) tick(3'b000);
        for (int r = 0; r < 5; r++) begin
            for (int n = 0; n < 6; n++) begin
                tick(n < 3 ? 3'b001 : 3'b000);
                n_total++;
                if ({level_o, press_o, release_o, long_o} !== exp_vec())
                    $display("FAIL bounce_model: got %b want %b",
                             {level_o, press_o, release_o, long_o}, exp_vec());
                else n_pass++;
                if (level_o[0] | press_o[0] | release_o[0] | long_o[0]) act++;
            end
        end
        n_total++;
        if (act != 0) $display("FAIL bounce_quiet: got %0d active cycles want 0", act);
        else n_pass++;
    endtask

    task automatic test_clean();
        int pe = 0, re = 0, hi = 0, pc = 0, rc = 0;
        for (int n = 1; n <= 18; n++) begin
            tick(n <= 8 ? 3'b010 : 3'b000);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== exp_vec())
                $display("FAIL clean_model edge%0d: got %b want %b", n,
                         {level_o, press_o, release_o, long_o}, exp_vec());
            else n_pass++;
            if (press_o[1]) begin pc++; pe = n; end
            if (release_o[1]) begin rc++; re = n; end
            if (level_o[1]) hi++;
        end
        n_total++;
        if (pe != 6 || pc != 1)
            $display("FAIL clean_press: got edge %0d x%0d want edge 6 x1", pe, pc);
        else n_pass++;
        n_total++;
        if (re != 14 || rc != 1)
            $display("FAIL clean_release: got edge %0d x%0d want edge 14 x1", re, rc);
        else n_pass++;
        n_total++;
        if (hi != 8) $display("FAIL clean_width: got %0d want 8", hi);
        else n_pass++;
    endtask

    task automatic test_gating();
        int pc = 0, rc = 0;
        ena = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick(3'b100);
            if (press_o != '0) pc++;
        end
        n_total++;
        if (level_o[2] !== 1'b1 || pc != 0)
            $display("FAIL gate_press: got level %b pulses %0d want 1 and 0",
                     level_o[2], pc);
        else n_pass++;
        ena = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick(3'b000);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== exp_vec())
                $display("FAIL gate_model: got %b want %b",
                         {level_o, press_o, release_o, long_o}, exp_vec());
            else n_pass++;
            if (release_o[2]) rc++;
        end
        n_total++;
        if (rc != 1) $display("FAIL gate_release: got %0d pulses want 1", rc);
        else n_pass++;
    endtask

    task automatic test_long();
        int pe = 0, le = 0, lc = 0;
        for (int n = 1; n <= 32; n++) begin
            tick(n <= 20 ? 3'b001 : 3'b000);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== exp_vec())
                $display("FAIL long_model edge%0d: got %b want %b", n,
                         {level_o, press_o, release_o, long_o}, exp_vec());
            else n_pass++;
            if (press_o[0]) pe = n;
            if (long_o != '0) begin lc++; le = n; end
        end
        n_total++;
        if (pe != 6) $display("FAIL long_press: got edge %0d want 6", pe);
        else n_pass++;
        n_total++;
        if (lc != (LONG_EN ? 1 : 0) || (LONG_EN && le != 16))
            $display("FAIL long_pulse: got %0d at edge %0d want %0d at edge 16",
                     lc, le, LONG_EN ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int first = 0;
        for (int n = 0; n < 8; n++) tick(3'b001);
        tick(3'b011);
        tick(3'b011);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({level_o, press_o, release_o, long_o} !== '0)
            $display("FAIL mid_reset_clear: got %b want 0",
                     {level_o, press_o, release_o, long_o});
        else n_pass++;
        tick(3'b011);
        tick(3'b011);
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick(3'b011);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== exp_vec())
                $display("FAIL mid_model edge%0d: got %b want %b", n,
                         {level_o, press_o, release_o, long_o}, exp_vec());
            else n_pass++;
            if (press_o === 3'b011 && first == 0) first = n;
        end
        n_total++;
        if (first != 6) $display("FAIL mid_latency: got edge %0d want 6", first);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [NB-1:0] b = btn_i;
        int run [NB];
        for (int c = 0; c < NB; c++) run[c] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (run[c] == 0) begin
                    b[c] = ~b[c];
                    run[c] = $urandom_range(1, 20);
                end
                run[c]--;
            end
            ena = ($urandom_range(0, 15) != 0);
            tick(b);
            n_total++;
            if ({level_o, press_o, release_o, long_o} !== exp_vec())
                $display("FAIL random_model step%0d: got %b want %b", n,
                         {level_o, press_o, release_o, long_o}, exp_vec());
            else n_pass++;
        end
        ena = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_clean();
        test_gating();
        test_long();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
